// File: rtl/sprite_pkg.sv
// Shared types and register map for the sprite attribute table controller.
package sprite_pkg;

   typedef struct packed {
      logic [4:0] id;
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] tile;
      logic       vis;
   } sprite_t;

   localparam logic [2:0] ADDR_ENTRY  = 3'd0;
   localparam logic [2:0] ADDR_COMMIT = 3'd1;
   localparam logic [2:0] ADDR_CLEAR  = 3'd2;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/sprite_table_ctrl_vblank_strobe.sv
// One-cycle-per-frame strobe taken from the first pixel of the vblank line.
module vblank_strobe
   import sprite_pkg::*;
#(
   parameter int VBLANK_LINE = 480
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] vga_hcount,
   input  logic [9:0] vga_vcount,
   output logic       vbs
);

   logic cond;
   logic c_reg;
   logic c_prev;

   assign cond = (vga_vcount == 10'(VBLANK_LINE)) && (vga_hcount == 10'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_reg  <= 1'b0;
         c_prev <= 1'b0;
      end else begin
         c_reg  <= cond;
         c_prev <= c_reg;
      end
   end

   // Rising edge only, so a timing generator that lingers on pixel 0 still yields one strobe.
   assign vbs = c_reg & ~c_prev;

endmodule

// File: rtl/sprite_table_ctrl.sv
// Avalon-MM sprite attribute table: shadow table written by software,
// copied to the active table at vblank after a commit, read by the renderer.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | accesses accepted; swap allowed on vblank strobe
//   CLEAR | shadow table swept to zero, one entry per cycle; bus stalled
module sprite_table_ctrl
   import sprite_pkg::*;
#(
   parameter int NSPRITES    = 32,
   parameter int VBLANK_LINE = 480
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        chipselect,
   input  logic                        write,
   input  logic [2:0]                  address,
   input  logic [31:0]                 writedata,
   output logic                        waitrequest,
   input  logic [9:0]                  vga_hcount,
   input  logic [9:0]                  vga_vcount,
   input  logic [$clog2(NSPRITES)-1:0] rd_idx,
   output logic [31:0]                 rd_entry,
   output logic                        commit_pend,
   output logic [15:0]                 frame_cnt
);

   localparam int IW = $clog2(NSPRITES);

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] clr_idx;
   logic [31:0]   shadow [NSPRITES];
   logic [31:0]   active [NSPRITES];

   sprite_t       wr_word;
   logic          acc;
   logic          acc_entry;
   logic          acc_commit;
   logic          acc_clear;
   logic          id_ok;
   logic          clr_last;
   logic          vbs;
   logic          swap;

   vblank_strobe #(
      .VBLANK_LINE (VBLANK_LINE)
   ) u_vbs (
      .clk        (clk),
      .reset_n    (reset_n),
      .vga_hcount (vga_hcount),
      .vga_vcount (vga_vcount),
      .vbs        (vbs)
   );

   assign wr_word     = writedata;
   assign waitrequest = (state == CLEAR) & chipselect;
   assign acc         = chipselect & write & ~waitrequest;
   assign acc_entry   = acc & (address == ADDR_ENTRY);
   assign acc_commit  = acc & (address == ADDR_COMMIT);
   assign acc_clear   = acc & (address == ADDR_CLEAR);
   assign id_ok       = ({27'd0, wr_word.id} < 32'(NSPRITES));
   assign clr_last    = (clr_idx == IW'(NSPRITES - 1));
   // A commit pending across a sweep waits for the first vblank after it.
   assign swap        = vbs & commit_pend & (state != CLEAR);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc_clear) state_nxt = CLEAR;
         CLEAR:   if (clr_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         clr_idx <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
         end else if (acc_clear) begin
            clr_idx <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSPRITES; i++) begin
            shadow[i] <= '0;
         end
      end else if (state == CLEAR) begin
         shadow[clr_idx] <= '0;
      end else if (acc_entry && id_ok) begin
         shadow[wr_word.id[IW-1:0]] <= wr_word;
      end
   end

   // Copies the pre-write shadow, so an ENTRY landing on the swap edge stays in shadow only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSPRITES; i++) begin
            active[i] <= '0;
         end
      end else if (swap) begin
         for (int i = 0; i < NSPRITES; i++) begin
            active[i] <= shadow[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_pend <= 1'b0;
         frame_cnt   <= '0;
         rd_entry    <= '0;
      end else begin
         if (acc_commit) begin
            commit_pend <= 1'b1;
         end else if (swap) begin
            commit_pend <= 1'b0;
         end
         if (vbs) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         rd_entry <= active[rd_idx];
      end
   end

endmodule
